// File: rtl/rbus_wrr_arbiter.sv
// Weighted round-robin rbus packet arbiter; a grant holds until i_stb && i_eop, then drops for one gap cycle.
// Latency: the grant is registered one cycle after eligibility; a requester keeps its turn while its credit lasts.
module rbus_wrr_arbiter #(
    parameter int N  = 5,
    parameter int WW = 4,
    parameter int IW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    cfg_en,
    input  logic [N*WW-1:0] cfg_weight,
    input  logic            i_stb,
    input  logic            i_eop,
    output logic [N-1:0]    o_gnt,
    output logic [IW-1:0]   o_gnt_id,
    output logic            o_gnt_vld,
    output logic            ff_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] last_ptr;
    logic [WW-1:0] credit;

    logic [N-1:0]  elig;
    logic          last_elig;
    logic          regrant;
    logic          hi_vld;
    logic [IW-1:0] hi_id;
    logic [IW-1:0] lo_id;
    logic [IW-1:0] next_id;
    logic [N-1:0]  next_onehot;
    logic [WW-1:0] wsel;
    logic [WW-1:0] load_val;

    assign elig = i_req & cfg_en;

    // hi_* is the first eligible index above last_ptr; lo_id is the lowest eligible
    // overall, which is the wrap-around choice (possibly last_ptr itself).
    always_comb begin
        last_elig = 1'b0;
        hi_vld    = 1'b0;
        hi_id     = '0;
        lo_id     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (last_ptr == IW'(k))
                last_elig = elig[k];
            if (elig[k] && (IW'(k) > last_ptr)) begin
                hi_vld = 1'b1;
                hi_id  = IW'(k);
            end
            if (elig[k])
                lo_id = IW'(k);
        end
    end

    assign regrant = last_elig && (credit != '0);

    always_comb begin
        if (regrant)
            next_id = last_ptr;
        else if (hi_vld)
            next_id = hi_id;
        else
            next_id = lo_id;
    end

    always_comb begin
        next_onehot = '0;
        wsel        = '0;
        for (int k = 0; k < N; k++) begin
            if (next_id == IW'(k)) begin
                next_onehot[k] = 1'b1;
                wsel           = cfg_weight[k*WW +: WW];
            end
        end
    end

    assign load_val = (wsel == '0) ? WW'(1) : wsel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            o_gnt     <= '0;
            o_gnt_id  <= '0;
            o_gnt_vld <= 1'b0;
            credit    <= '0;
            last_ptr  <= IW'(N - 1);
            ff_err    <= 1'b0;
        end else begin
            if (i_stb && (state == IDLE))
                ff_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        state     <= GRANT;
                        o_gnt     <= next_onehot;
                        o_gnt_id  <= next_id;
                        o_gnt_vld <= 1'b1;
                        last_ptr  <= next_id;
                        if (!regrant)
                            credit <= load_val;
                    end
                end
                GRANT: begin
                    if (i_stb && i_eop) begin
                        state     <= IDLE;
                        o_gnt     <= '0;
                        o_gnt_vld <= 1'b0;
                        if (credit != '0)
                            credit <= credit - WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rbus_wrr_arbiter.sv
// Directed bench for rbus_wrr_arbiter: inputs driven and outputs sampled 1ns after each rising edge.
module tb_rbus_wrr_arbiter;
    localparam int N  = 5;
    localparam int WW = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_req = '0;
    logic [N-1:0]    cfg_en = '0;
    logic [N*WW-1:0] cfg_weight = '0;
    logic            i_stb = 1'b0;
    logic            i_eop = 1'b0;
    logic [N-1:0]    o_gnt;
    logic [IW-1:0]   o_gnt_id;
    logic            o_gnt_vld;
    logic            ff_err;

    int n_tests = 0;
    int n_fail  = 0;

    rbus_wrr_arbiter #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .cfg_en    (cfg_en),
        .cfg_weight(cfg_weight),
        .i_stb     (i_stb),
        .i_eop     (i_eop),
        .o_gnt     (o_gnt),
        .o_gnt_id  (o_gnt_id),
        .o_gnt_vld (o_gnt_vld),
        .ff_err    (ff_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst   = 1'b1;
        i_stb = 1'b0;
        i_eop = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        i_req  = '1;
        cfg_en = '1;
        cfg_weight = {N{4'd1}};
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (o_gnt !== '0 || o_gnt_id !== '0 || o_gnt_vld !== 1'b0 || ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b id=%0d vld=%b err=%b, want all zero", o_gnt, o_gnt_id, o_gnt_vld, ff_err);
        end
        i_req = '0;
    endtask

    task automatic test_round_robin();
        int exp_id;
        do_reset();
        cfg_en     = '1;
        cfg_weight = {N{4'd1}};
        i_req      = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            exp_id = g % N;
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== 1'b1 || o_gnt_id !== IW'(exp_id) || o_gnt !== (5'd1 << exp_id)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: vld=%b id=%0d gnt=%b, want id=%0d", g, o_gnt_vld, o_gnt_id, o_gnt, exp_id);
            end
            i_stb = 1'b1;
            i_eop = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== 1'b0 || o_gnt !== '0) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: vld=%b gnt=%b, want 0/00000", g, o_gnt_vld, o_gnt);
            end
            i_stb = 1'b0;
            i_eop = 1'b0;
        end
        i_req = '0;
        n_tests++;
        if (ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_no_err: ff_err=%b, want 0", ff_err);
        end
    endtask

    task automatic test_weighted();
        int exp_seq[6] = '{0, 0, 1, 0, 0, 1};
        do_reset();
        cfg_en     = '1;
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
        i_req      = 5'b00011;
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== 1'b1 || o_gnt_id !== IW'(exp_seq[g])) begin
                n_fail++;
                $display("FAIL weighted[%0d]: vld=%b id=%0d, want id=%0d", g, o_gnt_vld, o_gnt_id, exp_seq[g]);
            end
            i_stb = 1'b1;
            i_eop = 1'b1;
            @(posedge clk); #1;
            i_stb = 1'b0;
            i_eop = 1'b0;
        end
        i_req = '0;
    endtask

    task automatic test_weight_change();
        int exp_seq[6] = '{0, 0, 0, 1, 0, 1};
        do_reset();
        cfg_en     = '1;
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd3};
        i_req      = 5'b00011;
        for (int g = 0; g < 6; g++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== 1'b1 || o_gnt_id !== IW'(exp_seq[g])) begin
                n_fail++;
                $display("FAIL weight_change[%0d]: vld=%b id=%0d, want id=%0d", g, o_gnt_vld, o_gnt_id, exp_seq[g]);
            end
            if (g == 0)
                cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
            i_stb = 1'b1;
            i_eop = 1'b1;
            @(posedge clk); #1;
            i_stb = 1'b0;
            i_eop = 1'b0;
        end
        i_req = '0;
    endtask

    task automatic test_hold();
        do_reset();
        cfg_en     = '1;
        cfg_weight = {N{4'd1}};
        i_req      = 5'b00100;
        @(posedge clk); #1;
        n_tests++;
        if (o_gnt_vld !== 1'b1 || o_gnt_id !== 3'd2 || o_gnt !== 5'b00100) begin
            n_fail++;
            $display("FAIL hold_first: vld=%b id=%0d gnt=%b, want 1/2/00100", o_gnt_vld, o_gnt_id, o_gnt);
        end
        i_req  = 5'b00001;
        cfg_en = 5'b11011;
        for (int c = 0; c < 3; c++) begin
            i_stb = (c == 2);
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== 1'b1 || o_gnt_id !== 3'd2 || o_gnt !== 5'b00100) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: vld=%b id=%0d gnt=%b, want 1/2/00100", c, o_gnt_vld, o_gnt_id, o_gnt);
            end
        end
        i_stb = 1'b1;
        i_eop = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (o_gnt_vld !== 1'b0 || o_gnt !== '0) begin
            n_fail++;
            $display("FAIL hold_release: vld=%b gnt=%b, want 0/00000", o_gnt_vld, o_gnt);
        end
        i_stb = 1'b0;
        i_eop = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (o_gnt_vld !== 1'b1 || o_gnt_id !== 3'd0 || o_gnt !== 5'b00001) begin
            n_fail++;
            $display("FAIL hold_next: vld=%b id=%0d gnt=%b, want 1/0/00001", o_gnt_vld, o_gnt_id, o_gnt);
        end
        i_stb = 1'b1;
        i_eop = 1'b1;
        @(posedge clk); #1;
        i_stb = 1'b0;
        i_eop = 1'b0;
        i_req = '0;
        cfg_en = '1;
        n_tests++;
        if (ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_err: ff_err=%b, want 0", ff_err);
        end
    endtask

    task automatic test_single_requester();
        logic exp_vld;
        do_reset();
        cfg_en     = '1;
        cfg_weight = {N{4'd1}};
        i_req      = 5'b01000;
        for (int c = 0; c < 9; c++) begin
            exp_vld = (c % 3 != 2);
            @(posedge clk); #1;
            n_tests++;
            if (o_gnt_vld !== exp_vld || (exp_vld && (o_gnt_id !== 3'd3 || o_gnt !== 5'b01000))) begin
                n_fail++;
                $display("FAIL single[%0d]: vld=%b id=%0d gnt=%b, want vld=%b id=3", c, o_gnt_vld, o_gnt_id, o_gnt, exp_vld);
            end
            i_stb = (c % 3 == 1);
            i_eop = (c % 3 == 1);
        end
        i_stb = 1'b0;
        i_eop = 1'b0;
        i_req = '0;
    endtask

    task automatic test_err();
        do_reset();
        i_req = '0;
        @(posedge clk); #1;
        n_tests++;
        if (ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: ff_err=%b, want 0", ff_err);
        end
        i_stb = 1'b1;
        @(posedge clk); #1;
        i_stb = 1'b0;
        n_tests++;
        if (ff_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: ff_err=%b, want 1", ff_err);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ff_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: ff_err=%b, want 1", ff_err);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (ff_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: ff_err=%b, want 0", ff_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        cfg_en     = '1;
        cfg_weight = {N{4'd1}};
        i_req      = 5'b10000;
        @(posedge clk); #1;
        n_tests++;
        if (o_gnt_vld !== 1'b1 || o_gnt_id !== 3'd4 || o_gnt !== 5'b10000) begin
            n_fail++;
            $display("FAIL rstmid_grant: vld=%b id=%0d gnt=%b, want 1/4/10000", o_gnt_vld, o_gnt_id, o_gnt);
        end
        i_stb = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if (o_gnt !== '0 || o_gnt_vld !== 1'b0 || o_gnt_id !== '0) begin
            n_fail++;
            $display("FAIL rstmid_drop: vld=%b id=%0d gnt=%b, want all zero", o_gnt_vld, o_gnt_id, o_gnt);
        end
        i_stb = 1'b0;
        i_req = 5'b10001;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (o_gnt_vld !== 1'b1 || o_gnt_id !== 3'd0 || o_gnt !== 5'b00001) begin
            n_fail++;
            $display("FAIL rstmid_after: vld=%b id=%0d gnt=%b, want 1/0/00001", o_gnt_vld, o_gnt_id, o_gnt);
        end
        i_stb = 1'b1;
        i_eop = 1'b1;
        @(posedge clk); #1;
        i_stb = 1'b0;
        i_eop = 1'b0;
        i_req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weighted();
        test_weight_change();
        test_hold();
        test_single_requester();
        test_err();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
